// File: rtl/zmips_wb_pkg.sv
// Shared constants, state encoding and helpers for the writeback-port arbiter.
package zmips_wb_pkg;

  localparam int RF_AW = 5;
  localparam int RF_DW = 32;

  localparam logic [RF_AW-1:0] PC_REG_HI = 5'd31;
  localparam logic [RF_AW-1:0] PC_REG_LO = 5'd30;

  typedef enum logic {
    WB_ARB,
    WB_LOCKED
  } wb_state_t;

  // Regs 30/31 alias the PC and must never be written through the port.
  function automatic logic is_pc_reg(input logic [RF_AW-1:0] addr);
    return &addr[4:1];
  endfunction

endpackage

// File: rtl/zmips_rr_pick.sv
// Combinational round-robin picker: first set request after last_i, wrapping.
module zmips_rr_pick #(
  parameter  int N  = 3,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  // Two passes: indices above last_i first, then wrap to 0..last_i.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (i > 32'(last_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
        any_o    = 1'b1;
      end
    end
    for (int unsigned i = 0; i < N; i++) begin
      if (!any_o && req_i[i] && (i <= 32'(last_i))) begin
        gnt_o[i] = 1'b1;
        idx_o    = IW'(i);
        any_o    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/zmips_wb_arbiter.sv
// Round-robin arbiter for the register file write port with optional
// ownership lock and idle-timeout release; rf_* outputs are registered.
module zmips_wb_arbiter
  import zmips_wb_pkg::*;
#(
  parameter  int N_REQ    = 3,
  parameter  int LOCK_MAX = 16,
  localparam int IW       = (N_REQ > 1) ? $clog2(N_REQ) : 1,
  localparam int TW       = $clog2(LOCK_MAX + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_valid,
  input  logic [N_REQ-1:0]       req_lock,
  input  logic [N_REQ*RF_AW-1:0] req_addr,
  input  logic [N_REQ*RF_DW-1:0] req_data,
  output logic [N_REQ-1:0]       req_ready,
  output logic                   rf_wr,
  output logic [RF_AW-1:0]       rf_wr_addr,
  output logic [RF_DW-1:0]       rf_wr_data,
  output logic [IW-1:0]          grant_id,
  output logic                   bad_addr,
  output logic                   lock_abort,
  output logic                   busy
);

  wb_state_t        state_q, state_d;
  logic [IW-1:0]    owner_q, owner_d;
  logic [IW-1:0]    last_q, last_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             rf_wr_q, rf_wr_d;
  logic [RF_AW-1:0] addr_q, addr_d;
  logic [RF_DW-1:0] data_q, data_d;
  logic [IW-1:0]    gid_q, gid_d;
  logic             bad_q, bad_d;
  logic             abort_q, abort_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             xfer;
  logic [IW-1:0]    xfer_idx;
  logic [RF_AW-1:0] xfer_addr;
  logic [RF_DW-1:0] xfer_data;
  logic             xfer_lock;

  zmips_rr_pick #(.N(N_REQ)) u_pick (
    .req_i  (req_valid),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  always_comb begin
    req_ready = '0;
    xfer      = 1'b0;
    xfer_idx  = owner_q;
    if (state_q == WB_ARB) begin
      req_ready = pick_gnt;
      xfer      = pick_any;
      xfer_idx  = pick_idx;
    end else begin
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if ((IW'(i) == owner_q) && req_valid[i]) begin
          req_ready[i] = 1'b1;
          xfer         = 1'b1;
        end
      end
    end
    if (rst) begin
      req_ready = '0;
      xfer      = 1'b0;
    end

    xfer_addr = '0;
    xfer_data = '0;
    xfer_lock = 1'b0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (IW'(i) == xfer_idx) begin
        xfer_addr = req_addr[RF_AW*i +: RF_AW];
        xfer_data = req_data[RF_DW*i +: RF_DW];
        xfer_lock = req_lock[i];
      end
    end
  end

  // A transfer always wins over timer expiry; expiry hands the RR pointer
  // to the owner so arbitration restarts at owner+1.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    timer_d = timer_q;
    rf_wr_d = 1'b0;
    addr_d  = addr_q;
    data_d  = data_q;
    gid_d   = gid_q;
    bad_d   = 1'b0;
    abort_d = 1'b0;
    if (xfer) begin
      last_d  = xfer_idx;
      gid_d   = xfer_idx;
      addr_d  = xfer_addr;
      data_d  = xfer_data;
      rf_wr_d = !is_pc_reg(xfer_addr);
      bad_d   = is_pc_reg(xfer_addr);
      timer_d = '0;
      if (xfer_lock) begin
        state_d = WB_LOCKED;
        owner_d = xfer_idx;
      end else begin
        state_d = WB_ARB;
      end
    end else if (state_q == WB_LOCKED) begin
      if (timer_q == TW'(LOCK_MAX - 1)) begin
        state_d = WB_ARB;
        abort_d = 1'b1;
        last_d  = owner_q;
        timer_d = '0;
      end else begin
        timer_d = timer_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= WB_ARB;
      owner_q <= '0;
      last_q  <= IW'(N_REQ - 1);
      timer_q <= '0;
      rf_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      gid_q   <= '0;
      bad_q   <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      rf_wr_q <= rf_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
      bad_q   <= bad_d;
      abort_q <= abort_d;
    end
  end

  assign rf_wr      = rf_wr_q;
  assign rf_wr_addr = addr_q;
  assign rf_wr_data = data_q;
  assign grant_id   = gid_q;
  assign bad_addr   = bad_q;
  assign lock_abort = abort_q;
  assign busy       = (state_q == WB_LOCKED);

endmodule

// File: tb/tb_zmips_wb_arbiter.sv
// Directed table-driven bench for zmips_wb_arbiter plus lock/timeout/reset sequences.
module tb_zmips_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [2:0]  req_valid = '0;
  logic [2:0]  req_lock = '0;
  logic [14:0] req_addr = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_ready;
  logic        rf_wr;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;
  logic [1:0]  grant_id;
  logic        bad_addr;
  logic        lock_abort;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  zmips_wb_arbiter #(.N_REQ(3), .LOCK_MAX(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_lock   (req_lock),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .rf_wr      (rf_wr),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data),
    .grant_id   (grant_id),
    .bad_addr   (bad_addr),
    .lock_abort (lock_abort),
    .busy       (busy)
  );

  logic [31:0] rf [32];
  always @(negedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (rf_wr) begin
      rf[rf_wr_addr] <= rf_wr_data;
    end
  end

  typedef struct {
    logic [2:0]  valid;
    logic [2:0]  lock;
    logic [4:0]  a0, a1, a2;
    logic [31:0] d0, d1, d2;
    logic [2:0]  rdy;
    logic        wr;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [1:0]  gid;
    logic        bad;
    logic        bsy;
  } vec_t;

  vec_t tbl [18];

  function automatic vec_t mk(input logic [2:0] v, input logic [2:0] l,
                              input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                              input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2,
                              input logic [2:0] rdy, input logic wr, input logic [4:0] ea,
                              input logic [31:0] ed, input logic [1:0] gid,
                              input logic bad, input logic bsy);
    vec_t t;
    t.valid = v; t.lock = l; t.a0 = a0; t.a1 = a1; t.a2 = a2;
    t.d0 = d0; t.d1 = d1; t.d2 = d2; t.rdy = rdy; t.wr = wr; t.addr = ea;
    t.data = ed; t.gid = gid; t.bad = bad; t.bsy = bsy;
    return t;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [2:0] v, input logic [2:0] l,
                       input logic [4:0] a0, input logic [4:0] a1, input logic [4:0] a2,
                       input logic [31:0] d0, input logic [31:0] d1, input logic [31:0] d2);
    req_valid = v;
    req_lock  = l;
    req_addr  = {a2, a1, a0};
    req_data  = {d2, d1, d0};
  endtask

  initial begin
    // RR from reset (last=2), single write, PC-mapped addresses, lock for 3 beats
    tbl[0]  = mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h10, 32'h11, 32'h12, 3'b001, 1'b1, 5'd1, 32'h10, 2'd0, 1'b0, 1'b0);
    tbl[1]  = mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h20, 32'h21, 32'h22, 3'b010, 1'b1, 5'd2, 32'h21, 2'd1, 1'b0, 1'b0);
    tbl[2]  = mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h30, 32'h31, 32'h32, 3'b100, 1'b1, 5'd3, 32'h32, 2'd2, 1'b0, 1'b0);
    tbl[3]  = mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h40, 32'h41, 32'h42, 3'b001, 1'b1, 5'd1, 32'h40, 2'd0, 1'b0, 1'b0);
    tbl[4]  = mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h50, 32'h51, 32'h52, 3'b010, 1'b1, 5'd2, 32'h51, 2'd1, 1'b0, 1'b0);
    tbl[5]  = mk(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'h60, 32'h61, 32'h62, 3'b100, 1'b1, 5'd3, 32'h62, 2'd2, 1'b0, 1'b0);
    tbl[6]  = mk(3'b010, 3'b000, 5'd0, 5'd5, 5'd0, 32'h0, 32'hDEADBEEF, 32'h0, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0);
    tbl[7]  = mk(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF, 2'd1, 1'b0, 1'b0);
    tbl[8]  = mk(3'b100, 3'b000, 5'd0, 5'd0, 5'd30, 32'h0, 32'h0, 32'h55, 3'b100, 1'b0, 5'd30, 32'h55, 2'd2, 1'b1, 1'b0);
    tbl[9]  = mk(3'b100, 3'b000, 5'd0, 5'd0, 5'd31, 32'h0, 32'h0, 32'h66, 3'b100, 1'b0, 5'd31, 32'h66, 2'd2, 1'b1, 1'b0);
    tbl[10] = mk(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd31, 32'h66, 2'd2, 1'b0, 1'b0);
    tbl[11] = mk(3'b111, 3'b001, 5'd7, 5'd8, 5'd9, 32'h70, 32'h71, 32'h72, 3'b001, 1'b1, 5'd7, 32'h70, 2'd0, 1'b0, 1'b1);
    tbl[12] = mk(3'b111, 3'b001, 5'd7, 5'd8, 5'd9, 32'h80, 32'h81, 32'h82, 3'b001, 1'b1, 5'd7, 32'h80, 2'd0, 1'b0, 1'b1);
    tbl[13] = mk(3'b111, 3'b001, 5'd7, 5'd8, 5'd9, 32'h90, 32'h91, 32'h92, 3'b001, 1'b1, 5'd7, 32'h90, 2'd0, 1'b0, 1'b1);
    tbl[14] = mk(3'b111, 3'b000, 5'd7, 5'd8, 5'd9, 32'hA0, 32'hA1, 32'hA2, 3'b001, 1'b1, 5'd7, 32'hA0, 2'd0, 1'b0, 1'b0);
    tbl[15] = mk(3'b111, 3'b000, 5'd7, 5'd8, 5'd9, 32'hB0, 32'hB1, 32'hB2, 3'b010, 1'b1, 5'd8, 32'hB1, 2'd1, 1'b0, 1'b0);
    tbl[16] = mk(3'b111, 3'b000, 5'd7, 5'd8, 5'd9, 32'hC0, 32'hC1, 32'hC2, 3'b100, 1'b1, 5'd9, 32'hC2, 2'd2, 1'b0, 1'b0);
    tbl[17] = mk(3'b000, 3'b000, 5'd0, 5'd0, 5'd0, 32'h0, 32'h0, 32'h0, 3'b000, 1'b0, 5'd9, 32'hC2, 2'd2, 1'b0, 1'b0);

    // Reset state, with requests asserted
    req_valid = 3'b111;
    #3;
    check("reset ready", 64'(req_ready), 64'd0);
    check("reset rf_wr", 64'(rf_wr), 64'd0);
    check("reset addr", 64'(rf_wr_addr), 64'd0);
    check("reset data", 64'(rf_wr_data), 64'd0);
    check("reset gid", 64'(grant_id), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    check("reset bad/abort", 64'({bad_addr, lock_abort}), 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 18; n++) begin
      @(negedge clk);
      drive(tbl[n].valid, tbl[n].lock, tbl[n].a0, tbl[n].a1, tbl[n].a2,
            tbl[n].d0, tbl[n].d1, tbl[n].d2);
      #1;
      check($sformatf("v%0d ready", n), 64'(req_ready), 64'(tbl[n].rdy));
      @(posedge clk);
      #1;
      check($sformatf("v%0d rf_wr", n), 64'(rf_wr), 64'(tbl[n].wr));
      check($sformatf("v%0d addr", n), 64'(rf_wr_addr), 64'(tbl[n].addr));
      check($sformatf("v%0d data", n), 64'(rf_wr_data), 64'(tbl[n].data));
      check($sformatf("v%0d gid", n), 64'(grant_id), 64'(tbl[n].gid));
      check($sformatf("v%0d bad", n), 64'(bad_addr), 64'(tbl[n].bad));
      check($sformatf("v%0d busy", n), 64'(busy), 64'(tbl[n].bsy));
    end
    check("rf r5", 64'(rf[5]), 64'hDEADBEEF);
    check("rf r30", 64'(rf[30]), 64'd0);
    check("rf r31", 64'(rf[31]), 64'd0);

    // Lock by req0, then 16 idle owner cycles with req1 waiting -> timeout
    @(negedge clk);
    drive(3'b001, 3'b001, 5'd4, 5'd6, 5'd0, 32'h1111, 32'h2222, 32'h0);
    @(posedge clk);
    #1;
    check("to lock busy", 64'(busy), 64'd1);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      drive(3'b010, 3'b000, 5'd4, 5'd6, 5'd0, 32'h1111, 32'h2222, 32'h0);
      #1;
      check($sformatf("to idle%0d ready", k), 64'(req_ready), 64'd0);
      check($sformatf("to idle%0d abort", k), 64'(lock_abort), 64'd0);
      @(posedge clk);
      #1;
    end
    check("to abort", 64'(lock_abort), 64'd1);
    check("to busy", 64'(busy), 64'd0);
    check("to rf_wr", 64'(rf_wr), 64'd0);
    check("to ready1", 64'(req_ready), 64'b010);
    @(posedge clk);
    #1;
    check("to abort clr", 64'(lock_abort), 64'd0);
    check("to grant1", 64'({rf_wr, grant_id, rf_wr_addr}), 64'({1'b1, 2'd1, 5'd6}));

    // Lock again, owner returns on the 16th idle cycle -> no abort
    @(negedge clk);
    drive(3'b001, 3'b001, 5'd4, 5'd6, 5'd0, 32'h3333, 32'h4444, 32'h0);
    @(posedge clk);
    for (int k = 1; k <= 15; k++) begin
      @(negedge clk);
      drive(3'b010, 3'b000, 5'd4, 5'd6, 5'd0, 32'h3333, 32'h4444, 32'h0);
      @(posedge clk);
    end
    @(negedge clk);
    drive(3'b011, 3'b000, 5'd12, 5'd6, 5'd0, 32'hCAFE, 32'h4444, 32'h0);
    #1;
    check("nt ready0", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    check("nt abort", 64'(lock_abort), 64'd0);
    check("nt write", 64'({rf_wr, grant_id, rf_wr_addr}), 64'({1'b1, 2'd0, 5'd12}));
    check("nt data", 64'(rf_wr_data), 64'hCAFE);
    check("nt busy", 64'(busy), 64'd0);
    @(negedge clk);
    drive(3'b010, 3'b000, 5'd4, 5'd6, 5'd0, 32'h0, 32'h4444, 32'h0);
    #1;
    check("nt next ready1", 64'(req_ready), 64'b010);

    // Asynchronous reset while locked with a beat on the port
    @(negedge clk);
    drive(3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 32'h77, 32'h0, 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(3'b001, 3'b001, 5'd3, 5'd0, 5'd0, 32'h78, 32'h0, 32'h0);
    @(posedge clk);
    #1;
    check("rs pre wr/busy", 64'({rf_wr, busy}), 64'b11);
    #2;
    rst = 1'b1;
    #1;
    check("rs rf_wr", 64'(rf_wr), 64'd0);
    check("rs busy", 64'(busy), 64'd0);
    check("rs ready", 64'(req_ready), 64'd0);
    check("rs outs", 64'({grant_id, rf_wr_addr, rf_wr_data}), 64'd0);
    @(negedge clk);
    drive(3'b111, 3'b000, 5'd1, 5'd2, 5'd3, 32'hE0, 32'hE1, 32'hE2);
    rst = 1'b0;
    #1;
    check("rs first ready", 64'(req_ready), 64'b001);
    @(posedge clk);
    #1;
    check("rs first grant", 64'({rf_wr, grant_id, rf_wr_addr}), 64'({1'b1, 2'd0, 5'd1}));
    @(negedge clk);
    req_valid = '0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
